// File: rtl/prog_loader.sv
// Serial program loader: receives a length-prefixed, XOR-checksummed frame of
// 16-bit instruction words, writes them to instruction memory, then releases the core.
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              core_halt,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    state_t          state;
    logic [7:0]      len_hi;
    logic [7:0]      hi_byte;
    logic [7:0]      xsum;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W:0] nwords;
    logic [ADDR_W:0] cnt_inc;
    logic [15:0]     len;
    logic            accept;

    assign rx_ready = (state != S_RUN) && (state != S_ERROR);
    assign accept   = rx_valid && rx_ready;
    assign len      = {len_hi, rx_data};
    assign cnt_inc  = cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            len_hi     <= '0;
            hi_byte    <= '0;
            xsum       <= '0;
            cnt        <= '0;
            nwords     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    len_hi <= rx_data;
                    xsum   <= rx_data;
                    state  <= S_LEN_LO;
                end
                S_LEN_LO: if (accept) begin
                    xsum <= xsum ^ rx_data;
                    cnt  <= '0;
                    if (len == 16'd0 || {1'b0, len} > MAX_LEN) begin
                        state    <= S_ERROR;
                        load_err <= 1'b1;
                    end else begin
                        nwords <= (ADDR_W+1)'(len);
                        state  <= S_DATA_HI;
                    end
                end
                S_DATA_HI: if (accept) begin
                    hi_byte <= rx_data;
                    xsum    <= xsum ^ rx_data;
                    state   <= S_DATA_LO;
                end
                S_DATA_LO: if (accept) begin
                    xsum       <= xsum ^ rx_data;
                    imem_we    <= 1'b1;
                    imem_addr  <= cnt[ADDR_W-1:0];
                    imem_wdata <= {hi_byte, rx_data};
                    cnt        <= cnt_inc;
                    state      <= (cnt_inc == nwords) ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: if (accept) begin
                    if (rx_data == xsum) begin
                        state <= S_RUN;
                    end else begin
                        state    <= S_ERROR;
                        load_err <= 1'b1;
                    end
                end
                // core_reset/load_done follow one cycle behind RUN entry
                S_RUN: begin
                    if (core_halt) begin
                        state      <= S_IDLE;
                        core_reset <= 1'b1;
                        load_done  <= 1'b0;
                    end else begin
                        core_reset <= 1'b0;
                        load_done  <= 1'b1;
                    end
                end
                S_ERROR: begin
                    load_err   <= 1'b1;
                    core_reset <= 1'b1;
                    load_done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
